// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port, fixed-latency memory between fetch (I) and data (D) requesters.
// Define CORE_MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module core_mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic        owner_d, owner_d_next;
  logic        owner_wr, owner_wr_next;
  logic        proto_err, proto_err_next;

  logic        expire, done, arb, grant, win_d, win_mis;
  logic        i_mis, d_mis, d_wr, resp, resp_err;
  logic [3:0]  d_be;
  logic [31:0] d_lanes, resp_data;

`ifdef CORE_MEM_ARB_RR_EN
  logic        last_d, last_d_next;
`endif

  // Data-side access decode: alignment check, byte enables and lane replication.
  always_comb begin
    i_mis   = (i_addr[1:0] != 2'b00);
    d_wr    = (d_size != 2'b00);
    d_mis   = 1'b0;
    d_be    = 4'b1111;
    d_lanes = d_wdata;
    case (d_size)
      2'b01: begin
        d_be    = 4'b0001 << d_addr[1:0];
        d_lanes = {4{d_wdata[7:0]}};
      end
      2'b10: begin
        d_mis   = d_addr[0];
        d_be    = d_addr[1] ? 4'b1100 : 4'b0011;
        d_lanes = {2{d_wdata[15:0]}};
      end
      default: d_mis = (d_addr[1:0] != 2'b00);
    endcase
  end

  // Arbitration happens when idle or on the cycle the outstanding access completes.
  always_comb begin
    expire = (state == BUSY) && (cnt == 3'd1);
    done   = expire && mem_rvalid;
    arb    = !rst && ((state == IDLE) || done);
    grant  = arb && (i_req || d_req);
`ifdef CORE_MEM_ARB_RR_EN
    win_d  = d_req && !(i_req && last_d);
`else
    win_d  = d_req;
`endif
    win_mis = win_d ? d_mis : i_mis;
    i_gnt   = grant && !win_d;
    d_gnt   = grant && win_d;
    mem_req = grant && !win_mis;
    mem_we  = mem_req && win_d && d_wr;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_be   = win_d ? d_be : 4'b1111;
      mem_addr = win_d ? {d_addr[ADDR_W-1:2], 2'b00} : {i_addr[ADDR_W-1:2], 2'b00};
      if (mem_we) begin
        mem_wdata = d_lanes;
      end
    end
  end

  // Response steering: only the owning port ever sees rvalid/err/rdata.
  always_comb begin
    resp      = !rst && (done || (state == ERR));
    resp_err  = (state == ERR);
    resp_data = (done && !owner_wr) ? mem_rdata : '0;
    i_rvalid  = resp && !owner_d;
    d_rvalid  = resp && owner_d;
    i_err     = i_rvalid && resp_err;
    d_err     = d_rvalid && resp_err;
    i_rdata   = i_rvalid ? resp_data : '0;
    d_rdata   = d_rvalid ? resp_data : '0;
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    owner_d_next   = owner_d;
    owner_wr_next  = owner_wr;
    proto_err_next = proto_err;
`ifdef CORE_MEM_ARB_RR_EN
    last_d_next    = last_d;
`endif
    if (mem_rvalid && !expire) begin
      proto_err_next = 1'b1;
    end
    case (state)
      BUSY: begin
        // A missing response at expiry holds the counter so the access can still finish.
        if (!expire) begin
          cnt_next = cnt - 3'd1;
        end else if (mem_rvalid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          proto_err_next = 1'b1;
        end
      end
      ERR:     state_next = IDLE;
      default: ;
    endcase
    if (grant) begin
      owner_d_next  = win_d;
      owner_wr_next = win_d && d_wr;
`ifdef CORE_MEM_ARB_RR_EN
      last_d_next   = win_d;
`endif
      if (win_mis) begin
        state_next = ERR;
        cnt_next   = '0;
      end else begin
        state_next = BUSY;
        cnt_next   = 3'(MEM_LAT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      owner_wr  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      owner_d   <= owner_d_next;
      owner_wr  <= owner_wr_next;
      proto_err <= proto_err_next;
    end
  end

`ifdef CORE_MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else begin
      last_d <= last_d_next;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed steps then random traffic against a transaction-level model.
module tb_core_mem_arbiter;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid, i_err;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_rvalid;

  core_mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    if (w == 64) return 32'h00A0_0093;
    return 32'h1357_0000 ^ (32'(w) * 32'h0001_0203);
  endfunction

  // Fixed-latency memory: command seen mid-cycle, response LAT cycles later.
  logic [31:0]    mem_arr [int];
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pd [LAT];
  logic           cap_v = 1'b0;
  logic [31:0]    cap_d = '0;
  logic           inject = 1'b0;

  assign mem_rvalid = pv[LAT-1] | inject;
  assign mem_rdata  = pv[LAT-1] ? pd[LAT-1] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    int w;
    logic [31:0] cur;
    cap_v = (mem_req === 1'b1);
    cap_d = 32'hFFFF_FFFF;
    if (mem_req === 1'b1) begin
      w   = int'(mem_addr[9:2]);
      cur = mem_arr.exists(w) ? mem_arr[w] : init_word(w);
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
        mem_arr[w] = cur;
      end else begin
        cap_d = cur;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = int'(LAT) - 1; k > 0; k--) pd[k] = pd[k-1];
    pd[0] = cap_d;
    pv    = (pv << 1) | LAT'(cap_v);
  end

  // Transaction-level reference model state.
  int          n_tests, n_fail, cyc, free_at, rp_at;
  logic        last_d, rp_v, rp_d, rp_err, eg_i, eg_d;
  logic [31:0] rp_data;
  logic [31:0] shadow [int];

  function automatic logic [31:0] sh_rd(input int w);
    return shadow.exists(w) ? shadow[w] : init_word(w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic issue(input logic take_d, output logic mreq, output logic we,
                       output logic [3:0] be, output logic [31:0] addr, output logic [31:0] wd);
    logic [31:0] a, cur;
    int ofs, w, n;
    a    = take_d ? d_addr : i_addr;
    ofs  = int'(a % 32'd4);
    w    = int'((a % 32'd1024) / 32'd4);
    n    = 4;
    if (take_d && d_size == 2'b01) n = 1;
    else if (take_d && d_size == 2'b10) n = 2;
    mreq = 1'b0; we = 1'b0; be = '0; addr = '0; wd = '0;
    rp_v = 1'b1; rp_d = take_d; rp_data = '0;
    if ((ofs % n) != 0) begin
      rp_err = 1'b1; rp_at = cyc + 1; free_at = cyc + 2;
      return;
    end
    rp_err = 1'b0; rp_at = cyc + int'(LAT); free_at = rp_at;
    mreq = 1'b1;
    addr = a - 32'(ofs);
    cur  = sh_rd(w);
    if (take_d && d_size != 2'b00) begin
      we = 1'b1;
      for (int b = ofs; b < ofs + n; b++) begin
        be[b] = 1'b1;
        cur[8*b +: 8] = d_wdata[8*(b-ofs) +: 8];
      end
      for (int b = 0; b < 4; b++) wd[8*b +: 8] = d_wdata[8*(b % n) +: 8];
      shadow[w] = cur;
    end else begin
      be = 4'hF;
      rp_data = cur;
    end
  endtask

  task automatic step();
    logic [31:0] e_ir, e_dr, e_addr, e_wd;
    logic        e_iv, e_ie, e_dv, e_de, e_mreq, e_we, take_d;
    logic [3:0]  e_be;
    @(negedge clk);
    {e_iv, e_ie, e_dv, e_de, e_mreq, e_we} = '0;
    e_ir = '0; e_dr = '0; e_addr = '0; e_wd = '0; e_be = '0;
    eg_i = 1'b0; eg_d = 1'b0;
    if (rst) begin
      rp_v = 1'b0; last_d = 1'b0; free_at = cyc + 1;
    end else begin
      if (rp_v && rp_at == cyc) begin
        if (rp_d) begin e_dv = 1'b1; e_de = rp_err; e_dr = rp_data; end
        else begin e_iv = 1'b1; e_ie = rp_err; e_ir = rp_data; end
        rp_v = 1'b0;
      end
      if (cyc >= free_at && (i_req || d_req)) begin
        if (i_req && d_req) begin
`ifdef CORE_MEM_ARB_RR_EN
          take_d = !last_d;
`else
          take_d = 1'b1;
`endif
        end else begin
          take_d = d_req;
        end
        last_d = take_d; eg_d = take_d; eg_i = !take_d;
        issue(take_d, e_mreq, e_we, e_be, e_addr, e_wd);
      end
    end
    chk("i_gnt", 32'(i_gnt), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("mem_req", 32'(mem_req), 32'(e_mreq));
    chk("i_rvalid", 32'(i_rvalid), 32'(e_iv));
    chk("i_err", 32'(i_err), 32'(e_ie));
    chk("i_rdata", i_rdata, e_ir);
    chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
    chk("d_err", 32'(d_err), 32'(e_de));
    chk("d_rdata", d_rdata, e_dr);
    if (e_mreq || rst) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_be", 32'(mem_be), 32'(e_be));
      chk("mem_addr", mem_addr, e_addr);
    end
    if (e_we || rst) chk("mem_wdata", mem_wdata, e_wd);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      if (eg_i) i_req = 1'b0;
      if (eg_d) d_req = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((i_req || d_req) && guard < 40) begin
      run(1);
      guard++;
    end
    chk("drain_timeout", 32'(i_req || d_req), 32'd0);
    run(int'(LAT) + 1);
  endtask

  task automatic wait_i();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!eg_i && guard < 40);
    chk("fetch_grant_timeout", 32'(eg_i), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a);
    i_req = 1'b1; i_addr = a;
  endtask

  task automatic dreq(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_size = s; d_addr = a; d_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255)) * 32'd4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; free_at = 0; rp_at = 0;
    last_d = 1'b0; rp_v = 1'b0; rp_d = 1'b0; rp_err = 1'b0; rp_data = '0;
    eg_i = 1'b0; eg_d = 1'b0;
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    run(3);
    rst = 1'b0;
    chk("proto_err_after_reset", 32'(dut.proto_err), 32'd0);

    fetch(32'h100); drain();
    fetch(32'h104); dreq(2'b00, 32'h200, '0); drain();
    fetch(32'h108); dreq(2'b00, 32'h204, '0); run(1);
    dreq(2'b11, 32'h208, 32'hCAFE_F00D); drain();

    dreq(2'b01, 32'h203, 32'h0000_005A); drain();
    dreq(2'b00, 32'h200, '0); drain();
    dreq(2'b10, 32'h101, 32'h0000_1234); drain();
    dreq(2'b10, 32'h102, 32'h0000_BEEF); drain();
    dreq(2'b11, 32'h202, 32'h0000_0001); drain();
    dreq(2'b00, 32'h201, '0); drain();
    fetch(32'h102); drain();
    dreq(2'b00, 32'h100, '0); drain();
    fetch(32'h10C); dreq(2'b10, 32'h105, 32'h0000_7777); drain();

    fetch(32'h100); run(1);
    rst = 1'b1; run(2);
    rst = 1'b0; run(1);
    fetch(32'h104); drain();

    for (int k = 0; k < 6; k++) begin
      fetch(32'h300 + 32'(4 * k));
      wait_i();
    end
    i_req = 1'b0; run(int'(LAT) + 1);

    chk("proto_err_clean", 32'(dut.proto_err), 32'd0);
    inject = 1'b1; run(1); inject = 1'b0;
    chk("proto_err_idle_stray", 32'(dut.proto_err), 32'd1);
    rst = 1'b1; run(1); rst = 1'b0;
    chk("proto_err_cleared", 32'(dut.proto_err), 32'd0);
    fetch(32'h110); run(1);
    inject = 1'b1; run(1); inject = 1'b0;
    drain();
    chk("proto_err_early_stray", 32'(dut.proto_err), 32'd1);
    rst = 1'b1; run(2); rst = 1'b0;

    for (int c = 0; c < 400; c++) begin
      if (!i_req && $urandom_range(0, 2) == 0) fetch(rand_addr());
      if (!d_req && $urandom_range(0, 1) == 0) dreq(2'($urandom_range(0, 3)), rand_addr(), $urandom());
      run(1);
    end
    drain();
    chk("proto_err_final", 32'(dut.proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
